ps2_mouse_init_seq: RTL and testbench
=====================================

// Module: ps2_mouse_init_seq
// PURPOSE
//  Command sequencer for the shared PS/2 rx/tx unit. Drives its wr_ps2/din side and consumes its rx_data stream.
//  Runs the mouse bring-up (reset, BAT/ID check, optional sample rate, stream enable), handles ACK/resend/timeouts,
//  then hands received bytes to the packet decoder. Sits between ps2_rxtx and the mouse packet FSM.
// PARAMETERS
//  ACK_TO_CYC   1_000_000   cycles allowed for tx_done or ACK after a command (20 ms @ 50 MHz)
//  BAT_TO_CYC   50_000_000  cycles allowed for each BAT (AA) / ID (00) byte after reset ACK
//  MAX_RETRY    3           resend attempts per command byte before error (0..7)
//  SAMPLE_RATE  8'd100      rate byte sent after F3 (SET_RATE_EN only)
// PORTS
//  CLK          in   1  system clock
//  RST_N        in   1  synchronous active-low reset
//  start        in   1  1-cycle pulse: begin/restart sequence (ignored while busy)
//  rx_data      in   8  byte from ps2_rxtx
//  rx_done_tick in   1  rx_data valid, 1 cycle
//  tx_done_tick in   1  command byte fully sent, 1 cycle
//  wr_ps2       out  1  1-cycle pulse to ps2_rxtx: send tx_byte
//  tx_byte      out  8  command byte to ps2_rxtx din, stable from wr_ps2 until next send
//  busy         out  1  sequence in progress
//  init_done    out  1  level: device streaming
//  init_err     out  1  level: sequence failed
//  err_code     out  2  0 none, 1 timeout, 2 retries exhausted, 3 bad BAT/ID/response
//  pkt_valid    out  1  1-cycle pulse, stream byte available (STREAM only)
//  pkt_byte     out  8  stream byte, registered copy of rx_data
// BEHAVIOUR
//  Reset (RST_N=0 at CLK edge): state IDLE, all outputs 0, step=0, retry=0, timer=0. Reset mid-transfer abandons it; RST_N also resets ps2_rxtx.
//  Command list (step index): FF, [F3, SAMPLE_RATE], F4. wr_ps2 registered: 1 cycle after SEND entry.
//  States:
//   IDLE     : start -> SEND, step=0, retry=0, busy=1, init_done=0, init_err=0, err_code=0.
//   SEND     : tx_byte=cmd[step], wr_ps2=1 for 1 cycle -> WAIT_TX.
//   WAIT_TX  : tx_done_tick -> WAIT_ACK; timer==ACK_TO_CYC -> ERROR(1).
//   WAIT_ACK : rx FA -> (step==0 ? WAIT_BAT : next step SEND, retry=0; after F4 -> STREAM);
//              rx FE -> retry<MAX_RETRY ? retry+1, SEND same step : ERROR(2); other byte -> ERROR(3); timeout -> ERROR(1).
//   WAIT_BAT : rx AA -> WAIT_ID; rx FC or other -> ERROR(3); timer==BAT_TO_CYC -> ERROR(1).
//   WAIT_ID  : rx 00 -> next step SEND; other -> ERROR(3); timeout BAT_TO_CYC -> ERROR(1).
//   STREAM   : init_done=1, busy=0; each rx_done_tick -> pkt_valid=1, pkt_byte=rx_data next cycle (latency 1).
//   ERROR    : init_err=1, busy=0, err_code held; start -> IDLE path (restart).
//  Timer: 26-bit up-counter, cleared on every state change and on each accepted rx byte; saturates, never wraps.
//  Timeout compare is >=, so a tick arriving on the exact timeout cycle loses: error wins.
//  rx_done_tick outside WAIT_ACK/WAIT_BAT/WAIT_ID/STREAM is dropped.
//  rx_done_tick and tx_done_tick in same cycle: only the one relevant to current state is used.
//  start in STREAM or ERROR restarts full sequence (init_done/init_err clear the next cycle); start while busy ignored.
//  pkt_valid never asserted outside STREAM; no bytes buffered across restart.
// CONFIGURATION
//  SET_RATE_EN defined  : sequence FF, F3, SAMPLE_RATE, F4 (4 steps, each ACKed, each with own retry budget).
//  SET_RATE_EN undefined: sequence FF, F4 (2 steps); SAMPLE_RATE unused.
// TESTING (ACK_TO_CYC=100, BAT_TO_CYC=500, MAX_RETRY=2)
//  1 Nominal: start; ack each tx with tx_done then FA; after FF send AA,00 -> wr_ps2 sees FF,(F3,64),F4; init_done=1, err_code=0.
//  2 Resend: reply FE to F4 twice then FA -> F4 sent 3 times total, init_done=1; FE x3 -> init_err=1, err_code=2.
//  3 Timeout: never pulse tx_done_tick after FF -> init_err=1, err_code=1 at 100 cycles post WAIT_TX entry, busy=0.
//  4 Bad BAT: reply FA then FC to FF -> init_err=1, err_code=3; then start -> FF resent, flags cleared.
//  5 Stream: in STREAM, rx 08,05,FB -> three pkt_valid pulses, pkt_byte 08,05,FB, each 1 cycle after rx_done_tick.
//  6 Reset mid-op: RST_N=0 during WAIT_ACK -> next edge all outputs 0, state IDLE; start re-runs from FF.

Source files
------------

// File: rtl/ps2_mouse_init_seq.sv
// PS/2 mouse bring-up sequencer: reset, BAT/ID check, optional sample rate, stream enable, then stream pass-through.
// Define SET_RATE_EN to insert "F3 <SAMPLE_RATE>" between the reset and the stream-enable commands.
module ps2_mouse_init_seq #(
    parameter int unsigned ACK_TO_CYC  = 1_000_000,
    parameter int unsigned BAT_TO_CYC  = 50_000_000,
    parameter int unsigned MAX_RETRY   = 3,
    parameter logic [7:0]  SAMPLE_RATE = 8'd100
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       start,
    input  logic [7:0] rx_data,
    input  logic       rx_done_tick,
    input  logic       tx_done_tick,
    output logic       wr_ps2,
    output logic [7:0] tx_byte,
    output logic       busy,
    output logic       init_done,
    output logic       init_err,
    output logic [1:0] err_code,
    output logic       pkt_valid,
    output logic [7:0] pkt_byte
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SEND, ST_WAIT_TX, ST_WAIT_ACK,
        ST_WAIT_BAT, ST_WAIT_ID, ST_STREAM, ST_ERROR
    } state_t;

    localparam logic [7:0]  RSP_ACK     = 8'hFA;
    localparam logic [7:0]  RSP_RESEND  = 8'hFE;
    localparam logic [7:0]  RSP_BAT_OK  = 8'hAA;
    localparam logic [7:0]  RSP_ID      = 8'h00;
    localparam logic [1:0]  ERR_NONE    = 2'd0;
    localparam logic [1:0]  ERR_TIMEOUT = 2'd1;
    localparam logic [1:0]  ERR_RETRY   = 2'd2;
    localparam logic [1:0]  ERR_BAD     = 2'd3;
    localparam logic [1:0]  LAST_STEP   = 2'd3;
    localparam logic [25:0] ACK_TO_L    = 26'(ACK_TO_CYC);
    localparam logic [25:0] BAT_TO_L    = 26'(BAT_TO_CYC);
    localparam logic [25:0] TIMER_MAX   = 26'h3FF_FFFF;
    localparam logic [2:0]  MAX_RETRY_L = 3'(MAX_RETRY);

    // Step slots are fixed (FF, F3, rate, F4); without the rate option the sequence jumps from FF to F4.
`ifdef SET_RATE_EN
    localparam logic [1:0]  STEP_AFTER_ID = 2'd1;
`else
    localparam logic [1:0]  STEP_AFTER_ID = 2'd3;
`endif

    function automatic logic [7:0] cmd_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    cmd_byte = 8'hFF;
            2'd1:    cmd_byte = 8'hF3;
            2'd2:    cmd_byte = SAMPLE_RATE;
            2'd3:    cmd_byte = 8'hF4;
            default: cmd_byte = 8'hFF;
        endcase
    endfunction

    state_t      state_r, state_nxt_s;
    logic [1:0]  step_r, step_nxt_s;
    logic [2:0]  retry_r, retry_nxt_s;
    logic [25:0] timer_r, timer_nxt_s;
    logic [1:0]  err_code_r, err_nxt_s;
    logic        rx_accept_s, busy_nxt_s, ack_to_s, bat_to_s, pkt_take_s;
    logic        wr_ps2_r, busy_r, init_done_r, init_err_r, pkt_valid_r;
    logic [7:0]  tx_byte_r, pkt_byte_r;

    assign ack_to_s   = (timer_r >= ACK_TO_L);
    assign bat_to_s   = (timer_r >= BAT_TO_L);
    assign pkt_take_s = (state_r == ST_STREAM) && rx_done_tick && !start;

    // Next-state, step/retry bookkeeping and error classification.
    always_comb begin
        state_nxt_s = state_r;
        step_nxt_s  = step_r;
        retry_nxt_s = retry_r;
        err_nxt_s   = err_code_r;
        rx_accept_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_STREAM, ST_ERROR: begin
                if (start) begin
                    state_nxt_s = ST_SEND;
                    step_nxt_s  = 2'd0;
                    retry_nxt_s = 3'd0;
                    err_nxt_s   = ERR_NONE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_SEND: state_nxt_s = ST_WAIT_TX;
            ST_WAIT_TX: begin
                if (ack_to_s) begin
                    state_nxt_s = ST_ERROR;
                    err_nxt_s   = ERR_TIMEOUT;
                end else if (tx_done_tick) begin
                    state_nxt_s = ST_WAIT_ACK;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_WAIT_ACK: begin
                if (ack_to_s) begin
                    state_nxt_s = ST_ERROR;
                    err_nxt_s   = ERR_TIMEOUT;
                end else if (rx_done_tick) begin
                    rx_accept_s = 1'b1;
                    if (rx_data == RSP_ACK) begin
                        retry_nxt_s = 3'd0;
                        if (step_r == 2'd0) begin
                            state_nxt_s = ST_WAIT_BAT;
                        end else if (step_r == LAST_STEP) begin
                            state_nxt_s = ST_STREAM;
                        end else begin
                            step_nxt_s  = step_r + 2'd1;
                            state_nxt_s = ST_SEND;
                        end
                    end else if (rx_data == RSP_RESEND) begin
                        if (retry_r < MAX_RETRY_L) begin
                            retry_nxt_s = retry_r + 3'd1;
                            state_nxt_s = ST_SEND;
                        end else begin
                            state_nxt_s = ST_ERROR;
                            err_nxt_s   = ERR_RETRY;
                        end
                    end else begin
                        state_nxt_s = ST_ERROR;
                        err_nxt_s   = ERR_BAD;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_WAIT_BAT, ST_WAIT_ID: begin
                if (bat_to_s) begin
                    state_nxt_s = ST_ERROR;
                    err_nxt_s   = ERR_TIMEOUT;
                end else if (rx_done_tick) begin
                    rx_accept_s = 1'b1;
                    if ((state_r == ST_WAIT_BAT) && (rx_data == RSP_BAT_OK)) begin
                        state_nxt_s = ST_WAIT_ID;
                    end else if ((state_r == ST_WAIT_ID) && (rx_data == RSP_ID)) begin
                        step_nxt_s  = STEP_AFTER_ID;
                        retry_nxt_s = 3'd0;
                        state_nxt_s = ST_SEND;
                    end else begin
                        state_nxt_s = ST_ERROR;
                        err_nxt_s   = ERR_BAD;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase

        busy_nxt_s = (state_nxt_s inside {ST_SEND, ST_WAIT_TX, ST_WAIT_ACK, ST_WAIT_BAT, ST_WAIT_ID});

        // Timer restarts on every state change or accepted byte and saturates instead of wrapping.
        if ((state_nxt_s != state_r) || rx_accept_s) begin
            timer_nxt_s = 26'd0;
        end else if (timer_r != TIMER_MAX) begin
            timer_nxt_s = timer_r + 26'd1;
        end else begin
            timer_nxt_s = timer_r;
        end
    end

    // State register and registered outputs; flags follow the state being entered.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r     <= ST_IDLE;
            step_r      <= 2'd0;
            retry_r     <= 3'd0;
            timer_r     <= 26'd0;
            err_code_r  <= ERR_NONE;
            wr_ps2_r    <= 1'b0;
            tx_byte_r   <= 8'h00;
            busy_r      <= 1'b0;
            init_done_r <= 1'b0;
            init_err_r  <= 1'b0;
            pkt_valid_r <= 1'b0;
            pkt_byte_r  <= 8'h00;
        end else begin
            state_r     <= state_nxt_s;
            step_r      <= step_nxt_s;
            retry_r     <= retry_nxt_s;
            timer_r     <= timer_nxt_s;
            err_code_r  <= err_nxt_s;
            wr_ps2_r    <= (state_r == ST_SEND);
            if (state_r == ST_SEND) begin
                tx_byte_r <= cmd_byte(step_r);
            end
            busy_r      <= busy_nxt_s;
            init_done_r <= (state_nxt_s == ST_STREAM);
            init_err_r  <= (state_nxt_s == ST_ERROR);
            pkt_valid_r <= pkt_take_s;
            if (pkt_take_s) begin
                pkt_byte_r <= rx_data;
            end
        end
    end

    assign wr_ps2    = wr_ps2_r;
    assign tx_byte   = tx_byte_r;
    assign busy      = busy_r;
    assign init_done = init_done_r;
    assign init_err  = init_err_r;
    assign err_code  = err_code_r;
    assign pkt_valid = pkt_valid_r;
    assign pkt_byte  = pkt_byte_r;

endmodule

// File: tb/tb_ps2_mouse_init_seq.sv
// Bench for ps2_mouse_init_seq: the bench plays the mouse, a command-level model predicts what gets sent.
module tb_ps2_mouse_init_seq;

    localparam int MAX_RETRY = 2;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       start = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done_tick = 1'b0;
    logic       tx_done_tick = 1'b0;
    logic       wr_ps2, busy, init_done, init_err, pkt_valid;
    logic [7:0] tx_byte, pkt_byte;
    logic [1:0] err_code;

    int pass_cnt = 0;
    int total_cnt = 0;
    int bad_pkt = 0;
    logic [7:0] sent_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] cmd_list[4];
    int n_cmds;
    int fe_cfg[4];
    logic [1:0] exp_err;
    bit seq_ok;

    ps2_mouse_init_seq #(.ACK_TO_CYC(100), .BAT_TO_CYC(500), .MAX_RETRY(MAX_RETRY)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .rx_data(rx_data),
        .rx_done_tick(rx_done_tick), .tx_done_tick(tx_done_tick),
        .wr_ps2(wr_ps2), .tx_byte(tx_byte), .busy(busy), .init_done(init_done),
        .init_err(init_err), .err_code(err_code), .pkt_valid(pkt_valid), .pkt_byte(pkt_byte)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (wr_ps2 === 1'b1) sent_q.push_back(tx_byte);
        if (pkt_valid === 1'b1 && init_done !== 1'b1) bad_pkt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic pulse_tx();
        tx_done_tick = 1'b1;
        @(negedge CLK);
        tx_done_tick = 1'b0;
    endtask

    task automatic pulse_rx(input logic [7:0] b);
        rx_data = b;
        rx_done_tick = 1'b1;
        @(negedge CLK);
        rx_done_tick = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic wait_wr(output bit ok, output logic [7:0] b);
        ok = 1'b0;
        b = 8'h00;
        for (int k = 0; k < 20; k++) begin
            if (wr_ps2 === 1'b1) begin
                ok = 1'b1;
                b = tx_byte;
                break;
            end
            @(negedge CLK);
        end
    endtask

    // Command-level model: each command goes out once per FE plus once for the final FA, unless FEs exceed the budget.
    function automatic void model_seq();
        exp_q.delete();
        exp_err = 2'd0;
        for (int i = 0; i < n_cmds; i++) begin
            if (fe_cfg[i] > MAX_RETRY) begin
                repeat (MAX_RETRY + 1) exp_q.push_back(cmd_list[i]);
                exp_err = 2'd2;
                break;
            end
            repeat (fe_cfg[i] + 1) exp_q.push_back(cmd_list[i]);
        end
    endfunction

    // Mouse behaviour: answer each command with fe_cfg[i] resends then an ACK; BAT/ID after the reset ACK.
    task automatic run_scenario();
        bit ok;
        bit aborted;
        logic [7:0] b;
        sent_q.delete();
        aborted = 1'b0;
        do_start();
        for (int i = 0; i < n_cmds && !aborted; i++) begin
            for (int a = 0; a <= fe_cfg[i] && !aborted; a++) begin
                wait_wr(ok, b);
                if (!ok) begin
                    aborted = 1'b1;
                end else begin
                    cyc($urandom_range(0, 4));
                    pulse_tx();
                    cyc($urandom_range(0, 4));
                    pulse_rx((a < fe_cfg[i]) ? 8'hFE : 8'hFA);
                end
            end
            if (!aborted && i == 0) begin
                cyc($urandom_range(0, 6));
                pulse_rx(8'hAA);
                cyc($urandom_range(0, 6));
                pulse_rx(8'h00);
            end
        end
        cyc(3);
        seq_ok = (sent_q.size() == exp_q.size());
        if (seq_ok) foreach (exp_q[k]) if (sent_q[k] !== exp_q[k]) seq_ok = 1'b0;
    endtask

    task automatic test_reset();
        cyc(3);
        total_cnt++;
        if ({wr_ps2, tx_byte, busy, init_done, init_err, err_code, pkt_valid, pkt_byte} !== 23'd0)
            $display("FAIL reset_outputs: got %h want 0", {wr_ps2, tx_byte, busy, init_done, init_err, err_code, pkt_valid, pkt_byte});
        else pass_cnt++;
        RST_N = 1'b1;
        cyc(3);
        total_cnt++;
        if ({wr_ps2, busy, init_done, init_err} !== 4'd0)
            $display("FAIL idle_outputs: got %b want 0000", {wr_ps2, busy, init_done, init_err});
        else pass_cnt++;
    endtask

    task automatic test_nominal();
        for (int i = 0; i < 4; i++) fe_cfg[i] = 0;
        model_seq();
        run_scenario();
        total_cnt++;
        if (!seq_ok) $display("FAIL nominal_seq: got %p want %p", sent_q, exp_q);
        else pass_cnt++;
        total_cnt++;
        if ({init_done, init_err, busy, err_code} !== 5'b10000)
            $display("FAIL nominal_flags: got done=%b err=%b busy=%b code=%0d want 1 0 0 0", init_done, init_err, busy, err_code);
        else pass_cnt++;
    endtask

    task automatic test_stream();
        logic [7:0] bytes[6];
        bytes[0] = 8'h08; bytes[1] = 8'h05; bytes[2] = 8'hFB;
        for (int i = 3; i < 6; i++) bytes[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 6; i++) begin
            cyc($urandom_range(0, 3));
            pulse_rx(bytes[i]);
            total_cnt++;
            if (pkt_valid !== 1'b1 || pkt_byte !== bytes[i])
                $display("FAIL stream_pkt%0d: got valid=%b byte=%h want 1 %h", i, pkt_valid, pkt_byte, bytes[i]);
            else pass_cnt++;
            cyc(1);
            total_cnt++;
            if (pkt_valid !== 1'b0) $display("FAIL stream_pulse%0d: got valid=%b want 0", i, pkt_valid);
            else pass_cnt++;
        end
    endtask

    task automatic test_latency();
        do_start();
        total_cnt++;
        if ({busy, init_done, wr_ps2} !== 3'b100)
            $display("FAIL restart_flags: got busy=%b done=%b wr=%b want 1 0 0", busy, init_done, wr_ps2);
        else pass_cnt++;
        cyc(1);
        total_cnt++;
        if (wr_ps2 !== 1'b1 || tx_byte !== 8'hFF)
            $display("FAIL send_latency: got wr=%b byte=%h want 1 ff", wr_ps2, tx_byte);
        else pass_cnt++;
        cyc(110);
    endtask

    task automatic test_resend();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 4; i++) fe_cfg[i] = 0;
            fe_cfg[n_cmds - 1] = (c == 0) ? 2 : 3;
            model_seq();
            run_scenario();
            total_cnt++;
            if (!seq_ok) $display("FAIL resend%0d_seq: got %p want %p", c, sent_q, exp_q);
            else pass_cnt++;
            total_cnt++;
            if (init_done !== (exp_err == 2'd0) || init_err !== (exp_err != 2'd0) || err_code !== exp_err)
                $display("FAIL resend%0d_flags: got done=%b err=%b code=%0d want code %0d", c, init_done, init_err, err_code, exp_err);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 4; i++) fe_cfg[i] = $urandom_range(0, 3);
            model_seq();
            run_scenario();
            total_cnt++;
            if (!seq_ok) $display("FAIL rand%0d_seq: got %p want %p", r, sent_q, exp_q);
            else pass_cnt++;
            total_cnt++;
            if (init_done !== (exp_err == 2'd0) || init_err !== (exp_err != 2'd0) || err_code !== exp_err || busy !== 1'b0)
                $display("FAIL rand%0d_flags: got done=%b err=%b code=%0d busy=%b want code %0d", r, init_done, init_err, err_code, busy, exp_err);
            else pass_cnt++;
        end
    endtask

    task automatic test_timeout();
        bit ok;
        logic [7:0] b;
        do_start();
        wait_wr(ok, b);
        pulse_rx(8'hFA);
        cyc(99);
        total_cnt++;
        if (init_err !== 1'b0 || busy !== 1'b1)
            $display("FAIL timeout_early: got err=%b busy=%b want 0 1", init_err, busy);
        else pass_cnt++;
        cyc(1);
        total_cnt++;
        if (init_err !== 1'b1 || err_code !== 2'd1 || busy !== 1'b0)
            $display("FAIL timeout_tx: got err=%b code=%0d busy=%b want 1 1 0", init_err, err_code, busy);
        else pass_cnt++;
        do_start();
        wait_wr(ok, b);
        cyc(100);
        pulse_tx();
        total_cnt++;
        if (init_err !== 1'b1 || err_code !== 2'd1)
            $display("FAIL tick_on_timeout: got err=%b code=%0d want 1 1", init_err, err_code);
        else pass_cnt++;
        do_start();
        wait_wr(ok, b);
        cyc(99);
        pulse_tx();
        total_cnt++;
        if (init_err !== 1'b0 || busy !== 1'b1)
            $display("FAIL tick_before_timeout: got err=%b busy=%b want 0 1", init_err, busy);
        else pass_cnt++;
        cyc(102);
        total_cnt++;
        if (init_err !== 1'b1 || err_code !== 2'd1)
            $display("FAIL timeout_ack: got err=%b code=%0d want 1 1", init_err, err_code);
        else pass_cnt++;
    endtask

    task automatic test_bad_bat();
        bit ok;
        logic [7:0] b;
        do_start();
        wait_wr(ok, b);
        pulse_tx();
        pulse_rx(8'hFA);
        pulse_rx(8'hFC);
        cyc(1);
        total_cnt++;
        if (init_err !== 1'b1 || err_code !== 2'd3)
            $display("FAIL bad_bat: got err=%b code=%0d want 1 3", init_err, err_code);
        else pass_cnt++;
        do_start();
        total_cnt++;
        if (init_err !== 1'b0 || err_code !== 2'd0 || busy !== 1'b1)
            $display("FAIL restart_clear: got err=%b code=%0d busy=%b want 0 0 1", init_err, err_code, busy);
        else pass_cnt++;
        wait_wr(ok, b);
        total_cnt++;
        if (!ok || b !== 8'hFF) $display("FAIL restart_ff: got ok=%b byte=%h want 1 ff", ok, b);
        else pass_cnt++;
    endtask

    task automatic test_reset_midop();
        bit ok;
        logic [7:0] b;
        pulse_tx();
        RST_N = 1'b0;
        cyc(1);
        total_cnt++;
        if ({wr_ps2, tx_byte, busy, init_done, init_err, err_code, pkt_valid, pkt_byte} !== 23'd0)
            $display("FAIL midop_reset: got %h want 0", {wr_ps2, tx_byte, busy, init_done, init_err, err_code, pkt_valid, pkt_byte});
        else pass_cnt++;
        RST_N = 1'b1;
        cyc(1);
        do_start();
        wait_wr(ok, b);
        total_cnt++;
        if (!ok || b !== 8'hFF) $display("FAIL midop_rerun: got ok=%b byte=%h want 1 ff", ok, b);
        else pass_cnt++;
        cyc(110);
        total_cnt++;
        if (bad_pkt !== 0) $display("FAIL stray_pkt: got %0d pulses outside stream want 0", bad_pkt);
        else pass_cnt++;
    endtask

    initial begin
`ifdef SET_RATE_EN
        cmd_list[0] = 8'hFF; cmd_list[1] = 8'hF3; cmd_list[2] = 8'h64; cmd_list[3] = 8'hF4;
        n_cmds = 4;
`else
        cmd_list[0] = 8'hFF; cmd_list[1] = 8'hF4; cmd_list[2] = 8'h00; cmd_list[3] = 8'h00;
        n_cmds = 2;
`endif
        test_reset();
        test_nominal();
        test_stream();
        test_latency();
        test_resend();
        test_random();
        test_timeout();
        test_bad_bat();
        test_reset_midop();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
